// File: rtl/axi4_master.sv
// ============================================================================
// Module   : axi4_master
// Purpose  : Single-outstanding AXI4 initiator that bridges a command/response
//            port to AXI4 write (AW+W+B) and read (AR+R) transactions.
//            Define AXI4_MASTER_BURST_EN to enable multi-beat reads (ar_len = cmd_len).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_master #(
    parameter int ID_WIDTH   = 11,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASTER_ID  = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [3:0]              cmd_len,

    output logic                    rsp_valid,
    output logic                    rsp_we,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_last,

    output logic [ID_WIDTH-1:0]     aw_id,
    output logic [ADDR_WIDTH-1:0]   aw_addr,
    output logic [7:0]              aw_len,
    output logic [2:0]              aw_size,
    output logic [1:0]              aw_burst,
    output logic                    aw_lock,
    output logic [3:0]              aw_cache,
    output logic [2:0]              aw_prot,
    output logic [3:0]              aw_qos,
    output logic [3:0]              aw_region,
    output logic [10:0]             aw_user,
    output logic                    aw_valid,
    input  logic                    aw_ready,

    output logic [ID_WIDTH-1:0]     ar_id,
    output logic [ADDR_WIDTH-1:0]   ar_addr,
    output logic [7:0]              ar_len,
    output logic [2:0]              ar_size,
    output logic [1:0]              ar_burst,
    output logic                    ar_lock,
    output logic [3:0]              ar_cache,
    output logic [2:0]              ar_prot,
    output logic [3:0]              ar_qos,
    output logic [3:0]              ar_region,
    output logic [10:0]             ar_user,
    output logic                    ar_valid,
    input  logic                    ar_ready,

    output logic [DATA_WIDTH-1:0]   dw_data,
    output logic [10:0]             dw_strb,
    output logic                    dw_last,
    output logic [10:0]             dw_user,
    output logic                    dw_valid,
    input  logic                    dw_ready,

    input  logic [ID_WIDTH-1:0]     dr_id,
    input  logic [DATA_WIDTH-1:0]   dr_data,
    input  logic [1:0]              dr_resp,
    input  logic                    dr_last,
    input  logic [10:0]             dr_user,
    input  logic                    dr_valid,
    output logic                    dr_ready,

    input  logic [ID_WIDTH-1:0]     b_id,
    input  logic [1:0]              b_resp,
    input  logic [10:0]             b_user,
    input  logic                    b_valid,
    output logic                    b_ready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RA   = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_we_q, rsp_we_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_last_q, rsp_last_d;

    // A channel counts as done once its handshake happened this or an earlier cycle.
    logic w_aw_ok;
    logic w_w_ok;
    assign w_aw_ok = aw_done_q | (aw_valid & aw_ready);
    assign w_w_ok  = w_done_q  | (dw_valid & dw_ready);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_valid) state_d = cmd_we ? S_WR : S_RA;
            S_WR:   if (w_aw_ok && w_w_ok) state_d = S_WB;
            S_WB:   if (b_valid) state_d = S_IDLE;
            S_RA:   if (ar_ready) state_d = S_RD;
            S_RD:   if (dr_valid && dr_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE) & rst;
        aw_valid  = (state_q == S_WR) & ~aw_done_q;
        dw_valid  = (state_q == S_WR) & ~w_done_q;
        b_ready   = (state_q == S_WB);
        ar_valid  = (state_q == S_RA);
        dr_ready  = (state_q == S_RD);
    end

    // ------------------------------------------------------------ datapath
    always_comb begin
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = 1'b0;
        rsp_we_d    = 1'b0;
        rsp_data_d  = '0;
        rsp_resp_d  = 2'b00;
        rsp_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    data_d    = cmd_data;
                    strb_d    = cmd_strb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_WR: begin
                aw_done_d = w_aw_ok;
                w_done_d  = w_w_ok;
            end
            S_WB: begin
                if (b_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_resp_d  = b_resp;
                end
            end
            S_RD: begin
                if (dr_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = dr_data;
                    rsp_resp_d  = dr_resp;
                    rsp_last_d  = dr_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_last_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

`ifdef AXI4_MASTER_BURST_EN
    logic [3:0] len_q, len_d;

    always_comb begin
        len_d = len_q;
        if (state_q == S_IDLE && cmd_valid) len_d = cmd_len;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) len_q <= 4'd0;
        else      len_q <= len_d;
    end

    assign ar_len = {4'b0000, len_q};

    logic w_unused_inputs;
    assign w_unused_inputs = ^{b_id, b_user, dr_id, dr_user};
`else
    assign ar_len = 8'd0;

    logic w_unused_inputs;
    assign w_unused_inputs = ^{b_id, b_user, dr_id, dr_user, cmd_len};
`endif

    // ------------------------------------------------------------- outputs
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_last  = rsp_last_q;

    assign aw_id     = ID_WIDTH'(MASTER_ID);
    assign aw_addr   = addr_q;
    assign aw_len    = 8'd0;
    assign aw_size   = 3'b010;
    assign aw_burst  = 2'b01;
    assign aw_lock   = 1'b0;
    assign aw_cache  = 4'd0;
    assign aw_prot   = 3'd0;
    assign aw_qos    = 4'd0;
    assign aw_region = 4'd0;
    assign aw_user   = 11'd0;

    assign ar_id     = ID_WIDTH'(MASTER_ID);
    assign ar_addr   = addr_q;
    assign ar_size   = 3'b010;
    assign ar_burst  = 2'b01;
    assign ar_lock   = 1'b0;
    assign ar_cache  = 4'd0;
    assign ar_prot   = 3'd0;
    assign ar_qos    = 4'd0;
    assign ar_region = 4'd0;
    assign ar_user   = 11'd0;

    assign dw_data   = data_q;
    assign dw_strb   = 11'(strb_q);
    assign dw_last   = 1'b1;
    assign dw_user   = 11'd0;

endmodule

`default_nettype wire

// File: tb/tb_axi4_master.sv
// ============================================================================
// Module   : tb_axi4_master
// Purpose  : Directed self-checking bench for axi4_master (writes, reads,
//            skewed handshakes, multi-beat reads, asynchronous reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_data = '0;
    logic [3:0]  cmd_strb = '0, cmd_len = '0;
    logic        rsp_valid, rsp_we, rsp_last;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;

    logic [10:0] aw_id, ar_id, aw_user, ar_user, dw_user, dw_strb;
    logic [31:0] aw_addr, ar_addr, dw_data;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst;
    logic        aw_lock, ar_lock, aw_valid, ar_valid, dw_last, dw_valid;
    logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic        aw_ready = 1'b0, ar_ready = 1'b0, dw_ready = 1'b0;

    logic [10:0] dr_id = '0, dr_user = '0, b_id = '0, b_user = '0;
    logic [31:0] dr_data = '0;
    logic [1:0]  dr_resp = '0, b_resp = '0;
    logic        dr_last = 1'b0, dr_valid = 1'b0, dr_ready;
    logic        b_valid = 1'b0, b_ready;

    int tests = 0;
    int fails = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_cnt = 0;

    axi4_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_last(rsp_last),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot),
        .aw_qos(aw_qos), .aw_region(aw_region), .aw_user(aw_user),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
        .ar_qos(ar_qos), .ar_region(ar_region), .ar_user(ar_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .dw_data(dw_data), .dw_strb(dw_strb), .dw_last(dw_last), .dw_user(dw_user),
        .dw_valid(dw_valid), .dw_ready(dw_ready),
        .dr_id(dr_id), .dr_data(dr_data), .dr_resp(dr_resp), .dr_last(dr_last),
        .dr_user(dr_user), .dr_valid(dr_valid), .dr_ready(dr_ready),
        .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            if (aw_valid && aw_ready) aw_hs <= aw_hs + 1;
            if (dw_valid && dw_ready) w_hs  <= w_hs + 1;
            if (b_valid  && b_ready)  b_hs  <= b_hs + 1;
            if (ar_valid && ar_ready) ar_hs <= ar_hs + 1;
            if (dr_valid && dr_ready) r_hs  <= r_hs + 1;
            if (rsp_valid)            rsp_cnt <= rsp_cnt + 1;
        end
    end

    task automatic idle_slave();
        aw_ready = 1'b0; dw_ready = 1'b0; ar_ready = 1'b0;
        b_valid = 1'b0; b_resp = 2'b00;
        dr_valid = 1'b0; dr_last = 1'b0; dr_data = '0; dr_resp = 2'b00;
    endtask

    // Presents a command and returns one sample-phase after the accept edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [3:0] len);
        bit ok;
        cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_strb = strb; cmd_len = len;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin @(posedge clk); #1; end
        cmd_valid = 1'b0;
        tests++;
        if (!ok) begin fails++; $display("FAIL cmd_accept: accepted=%0d required=1", ok); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({cmd_ready, aw_valid, dw_valid, ar_valid, b_ready, dr_ready, rsp_valid} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {cmd_ready, aw_valid, dw_valid, ar_valid, b_ready, dr_ready, rsp_valid});
        end
        tests++;
        if ({aw_size, ar_size, aw_burst, ar_burst, dw_last, aw_len, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, dw_user, aw_id} !== {3'b010, 3'b010, 2'b01, 2'b01, 1'b1,
             8'd0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 11'd0, 11'd0, 11'd0}) begin
            fails++;
            $display("FAIL const_outputs: size=%h/%h burst=%h/%h dw_last=%b required 2/2 1/1 1",
                     aw_size, ar_size, aw_burst, ar_burst, dw_last);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_zero_wait();
        int lat, aw0, w0, b0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        aw_ready = 1'b1; dw_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b00;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0);
        tests++;
        if ({aw_valid, dw_valid, aw_addr, dw_strb, dw_data} !== {2'b11, 32'h10, 11'h00F, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL wr_channels: aw_v=%b w_v=%b addr=%h strb=%h data=%h required 1 1 10 00f deadbeef",
                     aw_valid, dw_valid, aw_addr, dw_strb, dw_data);
        end
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d required 3", lat); end
        tests++;
        if ({rsp_we, rsp_resp, rsp_last, rsp_data, cmd_ready} !== {1'b1, 2'b00, 1'b1, 32'h0, 1'b1}) begin
            fails++;
            $display("FAIL wr_rsp: we=%b resp=%b last=%b data=%h cmd_ready=%b required 1 00 1 0 1",
                     rsp_we, rsp_resp, rsp_last, rsp_data, cmd_ready);
        end
        idle_slave();
        @(posedge clk); #1;
        tests++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rsp_pulse: got %b required 0", rsp_valid); end
        tests++;
        if ({aw_hs - aw0, w_hs - w0, b_hs - b0} !== {32'd1, 32'd1, 32'd1}) begin
            fails++;
            $display("FAIL wr_hs_count: aw=%0d w=%0d b=%0d required 1 1 1", aw_hs - aw0, w_hs - w0, b_hs - b0);
        end
    endtask

    task automatic test_write_skewed();
        int aw0, w0, b0, r0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; r0 = rsp_cnt;
        issue(1'b1, 32'h34, 32'hCAFE0001, 4'h3, 4'd0);
        b_valid = 1'b1; b_resp = 2'b01; aw_ready = 1'b1;
        @(posedge clk); #1;
        aw_ready = 1'b0;
        tests++;
        if ({aw_valid, dw_valid, b_ready} !== 3'b010) begin
            fails++;
            $display("FAIL skew_after_aw: aw_v=%b w_v=%b b_ready=%b required 0 1 0", aw_valid, dw_valid, b_ready);
        end
        @(posedge clk); #1;
        tests++;
        if ({dw_valid, dw_data, dw_strb} !== {1'b1, 32'hCAFE0001, 11'h003}) begin
            fails++;
            $display("FAIL skew_w_hold: w_v=%b data=%h strb=%h required 1 cafe0001 003", dw_valid, dw_data, dw_strb);
        end
        dw_ready = 1'b1;
        @(posedge clk); #1;
        dw_ready = 1'b0;
        tests++;
        if ({dw_valid, b_ready} !== 2'b01) begin
            fails++; $display("FAIL skew_after_w: w_v=%b b_ready=%b required 0 1", dw_valid, b_ready);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        tests++;
        if ({rsp_valid, rsp_we, rsp_resp, rsp_last} !== {1'b1, 1'b1, 2'b01, 1'b1}) begin
            fails++;
            $display("FAIL skew_rsp: valid=%b we=%b resp=%b last=%b required 1 1 01 1", rsp_valid, rsp_we, rsp_resp, rsp_last);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({aw_hs - aw0, w_hs - w0, b_hs - b0, rsp_cnt - r0} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            fails++;
            $display("FAIL skew_counts: aw=%0d w=%0d b=%0d rsp=%0d required 1 1 1 1",
                     aw_hs - aw0, w_hs - w0, b_hs - b0, rsp_cnt - r0);
        end
        idle_slave();
    endtask

    task automatic test_single_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int lat;
        ar_ready = 1'b1; dr_valid = 1'b1; dr_data = data; dr_resp = resp; dr_last = 1'b1;
        issue(1'b0, addr, 32'h0, 4'h0, 4'd0);
        tests++;
        if ({ar_valid, aw_valid, ar_addr, ar_len, ar_id} !== {1'b1, 1'b0, addr, 8'd0, 11'd0}) begin
            fails++;
            $display("FAIL rd_ar: ar_v=%b aw_v=%b addr=%h len=%h id=%h required 1 0 %h 00 000",
                     ar_valid, aw_valid, ar_addr, ar_len, ar_id, addr);
        end
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d required 3", lat); end
        tests++;
        if ({rsp_we, rsp_data, rsp_resp, rsp_last} !== {1'b0, data, resp, 1'b1}) begin
            fails++;
            $display("FAIL rd_rsp: we=%b data=%h resp=%b last=%b required 0 %h %b 1",
                     rsp_we, rsp_data, rsp_resp, rsp_last, data, resp);
        end
        idle_slave();
        @(posedge clk); #1;
        tests++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            fails++; $display("FAIL rd_done: rsp_v=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    // With the burst macro four beats are requested; without it the slave
    // asserts dr_last late (third beat) and every beat must still be forwarded.
    task automatic test_burst_read();
        int nb, r0;
        logic [7:0] exp_len;
`ifdef AXI4_MASTER_BURST_EN
        nb = 4; exp_len = 8'd3;
`else
        nb = 3; exp_len = 8'd0;
`endif
        r0 = r_hs;
        issue(1'b0, 32'h40, 32'h0, 4'h0, 4'd3);
        tests++;
        if ({ar_valid, ar_addr, ar_len} !== {1'b1, 32'h40, exp_len}) begin
            fails++;
            $display("FAIL burst_ar: ar_v=%b addr=%h len=%0d required 1 40 %0d", ar_valid, ar_addr, ar_len, exp_len);
        end
        ar_ready = 1'b1;
        @(posedge clk); #1;
        ar_ready = 1'b0;
        tests++;
        if ({ar_valid, dr_ready} !== 2'b01) begin
            fails++; $display("FAIL burst_rd_state: ar_v=%b dr_ready=%b required 0 1", ar_valid, dr_ready);
        end
        for (int i = 0; i < nb; i++) begin
            dr_valid = 1'b1; dr_data = 32'hA0 + i; dr_resp = 2'b00; dr_last = (i == nb - 1);
            @(posedge clk); #1;
            tests++;
            if ({rsp_valid, rsp_data, rsp_last} !== {1'b1, 32'hA0 + i, (i == nb - 1) ? 1'b1 : 1'b0}) begin
                fails++;
                $display("FAIL burst_beat%0d: valid=%b data=%h last=%b required 1 %h %0d",
                         i, rsp_valid, rsp_data, rsp_last, 32'hA0 + i, (i == nb - 1));
            end
        end
        idle_slave();
        @(posedge clk); #1;
        tests++;
        if ({rsp_valid, cmd_ready, r_hs - r0} !== {1'b0, 1'b1, nb}) begin
            fails++;
            $display("FAIL burst_end: rsp_v=%b cmd_ready=%b beats=%0d required 0 1 %0d",
                     rsp_valid, cmd_ready, r_hs - r0, nb);
        end
    endtask

    task automatic test_reset_mid_write();
        aw_ready = 1'b1; dw_ready = 1'b1;
        issue(1'b1, 32'h50, 32'h11112222, 4'hF, 4'd0);
        @(posedge clk); #1;
        tests++;
        if (b_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_wb: b_ready=%b required 1", b_ready); end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({cmd_ready, aw_valid, dw_valid, ar_valid, b_ready, dr_ready, rsp_valid} !== 7'b0) begin
            fails++;
            $display("FAIL rstmid_outputs: got %b required 0000000",
                     {cmd_ready, aw_valid, dw_valid, ar_valid, b_ready, dr_ready, rsp_valid});
        end
        idle_slave();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b required 1", cmd_ready); end
        @(posedge clk); #1;
        test_single_read(32'h80, 32'h12345678, 2'b00);
    endtask

    initial begin
        idle_slave();
        test_reset();
        test_write_zero_wait();
        test_write_skewed();
        test_single_read(32'h20, 32'h20, 2'b10);
        test_burst_read();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
